timer_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single memory-mapped timer register port (valid/strb/addr/data, one-cycle ready) among NREQ bus requesters. It sits between the request masters (CPU-side bus bridge, parking-gate sequencer, debug port) and the timer's configuration port. It serialises accesses, forwards the winner's write, and returns a per-requester completion pulse. Accesses the timer never acknowledges are terminated by an optional timeout.

---
 rtl/timer_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_timer_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter sharing the timer configuration port among NREQ requesters.
// Define TIMER_ARB_TIMEOUT_EN to compile in the BUSY timeout abort (req_err path).
module timer_bus_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16,
   parameter int GW      = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [4*NREQ-1:0]    req_strb,
   input  logic [3*NREQ-1:0]    req_addr,
   input  logic [32*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      req_err,
   output logic                 m_valid,
   output logic [3:0]           m_strb,
   output logic [2:0]           m_addr,
   output logic [31:0]          m_data,
   input  logic                 m_ready,
   output logic [GW-1:0]        grant_id
);

   // A misconfigured instance never grants, so it can never drive the timer port.
   localparam bit CFG_OK = (NREQ >= 2) && (NREQ <= 8) && (TIMEOUT >= 2);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_r;
   logic              m_valid_r;
   logic [3:0]        m_strb_r;
   logic [2:0]        m_addr_r;
   logic [31:0]       m_data_r;
   logic [NREQ-1:0]   req_ready_r;
   logic [GW-1:0]     grant_id_r;
   logic [GW-1:0]     last_grant_r;

`ifdef TIMER_ARB_TIMEOUT_EN
   localparam int             CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]  TMO_MAX  = CW'(TIMEOUT);

   logic [NREQ-1:0]   req_err_r;
   logic [CW-1:0]     tmo_cnt_r;
`endif

   logic              win_found_s;
   logic              cand_hit_s;
   logic              grant_ok_s;
   logic [GW-1:0]     cand_idx_s;
   logic [GW-1:0]     win_idx_s;
   logic [3:0]        win_strb_s;
   logic [2:0]        win_addr_s;
   logic [31:0]       win_data_s;

   function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] idx);
      logic [NREQ-1:0] vec;
      vec = '0;
      for (int i = 0; i < NREQ; i++) begin
         vec[i] = (GW'(i) == idx);
      end
      return vec;
   endfunction

   // Round-robin search starting one past the last grant, then payload select of the winner.
   always_comb begin
      win_found_s = 1'b0;
      cand_hit_s  = 1'b0;
      cand_idx_s  = '0;
      win_idx_s   = last_grant_r;
      win_strb_s  = 4'h0;
      win_addr_s  = 3'h0;
      win_data_s  = 32'h0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_idx_s  = GW'((int'(last_grant_r) + k) % NREQ);
         cand_hit_s  = req_valid[cand_idx_s] & ~win_found_s;
         win_idx_s   = cand_hit_s ? cand_idx_s : win_idx_s;
         win_found_s = win_found_s | cand_hit_s;
      end
      for (int i = 0; i < NREQ; i++) begin
         win_strb_s = win_strb_s | (req_strb[4*i +: 4]  & {4{GW'(i) == win_idx_s}});
         win_addr_s = win_addr_s | (req_addr[3*i +: 3]  & {3{GW'(i) == win_idx_s}});
         win_data_s = win_data_s | (req_data[32*i +: 32] & {32{GW'(i) == win_idx_s}});
      end
      grant_ok_s = win_found_s & CFG_OK;
   end

   // Arbitration FSM; every output is a register written here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         m_valid_r    <= 1'b0;
         m_strb_r     <= 4'h0;
         m_addr_r     <= 3'h0;
         m_data_r     <= 32'h0;
         req_ready_r  <= '0;
         grant_id_r   <= '0;
         last_grant_r <= GW'(NREQ - 1);
`ifdef TIMER_ARB_TIMEOUT_EN
         req_err_r    <= '0;
         tmo_cnt_r    <= '0;
`endif
      end else begin
         req_ready_r <= '0;
`ifdef TIMER_ARB_TIMEOUT_EN
         req_err_r   <= '0;
`endif
         case (state_r)
            ST_IDLE: begin
               if (grant_ok_s) begin
                  m_valid_r    <= 1'b1;
                  m_strb_r     <= win_strb_s;
                  m_addr_r     <= win_addr_s;
                  m_data_r     <= win_data_s;
                  grant_id_r   <= win_idx_s;
                  last_grant_r <= win_idx_s;
`ifdef TIMER_ARB_TIMEOUT_EN
                  tmo_cnt_r    <= '0;
`endif
                  state_r      <= ST_BUSY;
               end else begin
                  m_valid_r    <= 1'b0;
                  state_r      <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (m_ready) begin
                  m_valid_r   <= 1'b0;
                  req_ready_r <= onehot(grant_id_r);
                  state_r     <= ST_DONE;
               end
`ifdef TIMER_ARB_TIMEOUT_EN
               // tmo_cnt_r counts BUSY cycles already spent without an acknowledge.
               else if (tmo_cnt_r >= TMO_LAST) begin
                  m_valid_r <= 1'b0;
                  req_err_r <= onehot(grant_id_r);
                  state_r   <= ST_DONE;
               end else begin
                  tmo_cnt_r <= (tmo_cnt_r == TMO_MAX) ? tmo_cnt_r : tmo_cnt_r + CW'(1);
                  state_r   <= ST_BUSY;
               end
`else
               else begin
                  state_r <= ST_BUSY;
               end
`endif
            end
            ST_DONE: begin
               m_valid_r <= 1'b0;
               state_r   <= ST_IDLE;
            end
            default: begin
               m_valid_r <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_valid   = m_valid_r;
   assign m_strb    = m_strb_r;
   assign m_addr    = m_addr_r;
   assign m_data    = m_data_r;
   assign req_ready = req_ready_r;
   assign grant_id  = grant_id_r;
`ifdef TIMER_ARB_TIMEOUT_EN
   assign req_err   = req_err_r;
`else
   assign req_err   = '0;
`endif

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Self-checking bench for timer_bus_arbiter: vector table, timer responder model and
// an in-order completion scoreboard, plus hand-written multi-cycle sequences.
module tb_timer_bus_arbiter;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;
   localparam int GW      = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [4*NREQ-1:0]   req_strb  = '0;
   logic [3*NREQ-1:0]   req_addr  = '0;
   logic [32*NREQ-1:0]  req_data  = '0;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ-1:0]     req_err;
   logic                m_valid;
   logic [3:0]          m_strb;
   logic [2:0]          m_addr;
   logic [31:0]         m_data;
   logic                m_ready = 1'b0;
   logic [GW-1:0]       grant_id;

   timer_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .GW(GW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_strb(req_strb), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .req_err(req_err),
      .m_valid(m_valid), .m_strb(m_strb), .m_addr(m_addr), .m_data(m_data),
      .m_ready(m_ready), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              idx;
      logic [2:0]      addr;
      logic [3:0]      strb;
      logic [31:0]     data;
      logic [GW-1:0]   exp_gid;
      logic [NREQ-1:0] exp_ready;
   } vec_t;

   typedef struct {
      logic [GW-1:0] gid;
      logic [2:0]    addr;
      logic [3:0]    strb;
      logic [31:0]   data;
      bit            is_err;
   } exp_t;

   exp_t        exp_q[$];
   int          rise_q[$];
   int          n_vec = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          rearm_left[NREQ];
   logic        force_ack = 1'b0;
   logic        seen_prev = 1'b0;
   logic        prev_valid = 1'b0;
   logic [2:0]  cap_addr = 3'h0;
   logic [3:0]  cap_strb = 4'h0;
   logic [31:0] cap_data = 32'h0;
   vec_t        vecs[5];
   vec_t        v_fresh;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
      req_valid[i]        = 1'b1;
      req_addr[3*i +: 3]  = a;
      req_strb[4*i +: 4]  = s;
      req_data[32*i +: 32] = d;
   endtask

   task automatic push_exp(input int i, input logic [2:0] a, input logic [3:0] s, input logic [31:0] d,
                           input bit is_err);
      exp_t e;
      e.gid = GW'(i); e.addr = a; e.strb = s; e.data = d; e.is_err = is_err;
      exp_q.push_back(e);
   endtask

   // One cycle: timer responder, monitor/scoreboard, then requester agents.
   task automatic tick();
      logic [NREQ-1:0] pulse;
      exp_t            e;
      @(negedge clk);
      cyc++;
      m_ready   = m_valid && seen_prev && ((m_addr <= 3'd4) || force_ack);
      seen_prev = m_valid;
      if (m_valid && !prev_valid) begin
         cap_addr = m_addr; cap_strb = m_strb; cap_data = m_data;
         rise_q.push_back(cyc);
      end else if (m_valid) begin
         chk("payload_stable", {25'd0, m_strb, m_addr, m_data}, {25'd0, cap_strb, cap_addr, cap_data});
      end
      prev_valid = m_valid;
      pulse = req_ready | req_err;
      if (pulse != '0) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_pulse: got ready=0x%0h err=0x%0h, expected none (cycle %0d)",
                     req_ready, req_err, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("sb_grant_id", 64'(grant_id), 64'(e.gid));
            chk("sb_req_ready", 64'(req_ready), e.is_err ? 64'd0 : 64'(1 << e.gid));
            chk("sb_req_err", 64'(req_err), e.is_err ? 64'(1 << e.gid) : 64'd0);
            chk("sb_payload", {25'd0, cap_strb, cap_addr, cap_data}, {25'd0, e.strb, e.addr, e.data});
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (pulse[i]) begin
            if (rearm_left[i] > 0) begin
               rearm_left[i]--;
               req_data[32*i +: 32] = req_data[32*i +: 32] + 32'd1;
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      force_ack = 1'b0;
      for (int i = 0; i < NREQ; i++) rearm_left[i] = 0;
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Single transaction with cycle-exact checks; called at the negedge of cycle 0.
   task automatic run_vec(input vec_t v);
      set_req(v.idx, v.addr, v.strb, v.data);
      push_exp(v.idx, v.addr, v.strb, v.data, 1'b0);
      tick();
      chk("c1_m_valid", 64'(m_valid), 64'd1);
      chk("c1_m_addr", 64'(m_addr), 64'(v.addr));
      chk("c1_m_strb", 64'(m_strb), 64'(v.strb));
      chk("c1_m_data", 64'(m_data), 64'(v.data));
      chk("c1_grant_id", 64'(grant_id), 64'(v.exp_gid));
      tick();
      chk("c2_m_valid", 64'(m_valid), 64'd1);
      chk("c2_req_ready", 64'(req_ready), 64'd0);
      tick();
      chk("c3_m_valid", 64'(m_valid), 64'd0);
      chk("c3_req_ready", 64'(req_ready), 64'(v.exp_ready));
      chk("c3_req_err", 64'(req_err), 64'd0);
      tick();
      chk("c4_req_ready", 64'(req_ready), 64'd0);
   endtask

   initial begin
      int t0;
      vecs[0] = '{idx: 2, addr: 3'd0, strb: 4'h1, data: 32'd1,          exp_gid: 2'd2, exp_ready: 4'b0100};
      vecs[1] = '{idx: 0, addr: 3'd4, strb: 4'hF, data: 32'hDEADBEEF,   exp_gid: 2'd0, exp_ready: 4'b0001};
      vecs[2] = '{idx: 3, addr: 3'd1, strb: 4'hC, data: 32'h12345678,   exp_gid: 2'd3, exp_ready: 4'b1000};
      vecs[3] = '{idx: 1, addr: 3'd2, strb: 4'h3, data: 32'hA5A55A5A,   exp_gid: 2'd1, exp_ready: 4'b0010};
      vecs[4] = '{idx: 1, addr: 3'd3, strb: 4'h8, data: 32'h00000000,   exp_gid: 2'd1, exp_ready: 4'b0010};
      v_fresh = '{idx: 0, addr: 3'd2, strb: 4'hF, data: 32'h0BADF00D,   exp_gid: 2'd0, exp_ready: 4'b0001};

      // Reset state
      do_reset();
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_strb", 64'(m_strb), 64'd0);
      chk("rst_m_addr", 64'(m_addr), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_req_err", 64'(req_err), 64'd0);
      chk("rst_grant_id", 64'(grant_id), 64'd0);

      // Table of single transactions
      for (int v = 0; v < 5; v++) run_vec(vecs[v]);

      // All four requesters at once after reset: grants 0,1,2,3, four cycles apart
      do_reset();
      rise_q.delete();
      for (int i = 0; i < NREQ; i++) begin
         set_req(i, 3'(i), 4'(i + 1), 32'd100 + 32'(i));
         push_exp(i, 3'(i), 4'(i + 1), 32'd100 + 32'(i), 1'b0);
      end
      t0 = cyc;
      wait_done("all4_complete", 60);
      idle(6);
      chk("all4_rises", 64'(rise_q.size()), 64'd4);
      if (rise_q.size() == 4) begin
         chk("all4_first_rise", 64'(rise_q[0] - t0), 64'd1);
         for (int k = 1; k < 4; k++) chk("all4_rise_spacing", 64'(rise_q[k] - rise_q[k-1]), 64'd4);
      end
      chk("all4_released", 64'(req_valid), 64'd0);

      // Requesters 1 and 3 keep re-requesting right after 1 was served: 3,1,3,1
      do_reset();
      run_vec(vecs[3]);
      rearm_left[1] = 1;
      rearm_left[3] = 1;
      set_req(1, 3'd1, 4'hF, 32'd100);
      set_req(3, 3'd3, 4'h3, 32'd300);
      push_exp(3, 3'd3, 4'h3, 32'd300, 1'b0);
      push_exp(1, 3'd1, 4'hF, 32'd100, 1'b0);
      push_exp(3, 3'd3, 4'h3, 32'd301, 1'b0);
      push_exp(1, 3'd1, 4'hF, 32'd101, 1'b0);
      wait_done("alt_complete", 60);
      idle(6);
      chk("alt_released", 64'(req_valid), 64'd0);

      // Unacknowledged access (address 5)
      do_reset();
      set_req(1, 3'd5, 4'hF, 32'h55);
`ifdef TIMER_ARB_TIMEOUT_EN
      push_exp(1, 3'd5, 4'hF, 32'h55, 1'b1);
      for (int k = 1; k <= TIMEOUT; k++) begin
         tick();
         chk("tmo_m_valid_busy", 64'(m_valid), 64'd1);
         chk("tmo_no_pulse", 64'({req_ready, req_err}), 64'd0);
      end
      tick();
      chk("tmo_m_valid_done", 64'(m_valid), 64'd0);
      chk("tmo_req_err", 64'(req_err), 64'b0010);
      chk("tmo_req_ready", 64'(req_ready), 64'd0);
      tick();
      chk("tmo_err_one_cycle", 64'(req_err), 64'd0);
`else
      push_exp(1, 3'd5, 4'hF, 32'h55, 1'b0);
      for (int k = 1; k <= TIMEOUT + 4; k++) begin
         tick();
         chk("notmo_m_valid_held", 64'(m_valid), 64'd1);
         chk("notmo_no_pulse", 64'({req_ready, req_err}), 64'd0);
      end
      force_ack = 1'b1;
      wait_done("notmo_late_ack", 10);
      force_ack = 1'b0;
`endif
      idle(2);

      // Reset during BUSY aborts without a pulse; a fresh request is then served
      do_reset();
      set_req(2, 3'd0, 4'h1, 32'd7);
      tick();
      chk("rstbusy_m_valid_c1", 64'(m_valid), 64'd1);
      rst = 1'b1;
      req_valid = '0;
      tick();
      rst = 1'b0;
      chk("rstbusy_m_valid", 64'(m_valid), 64'd0);
      chk("rstbusy_grant_id", 64'(grant_id), 64'd0);
      chk("rstbusy_no_pulse", 64'({req_ready, req_err}), 64'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rstbusy_quiet", 64'({m_valid, req_ready, req_err}), 64'd0);
      end
      run_vec(v_fresh);

      // Payload change mid-BUSY is ignored
      set_req(3, 3'd2, 4'hF, 32'd50);
      push_exp(3, 3'd2, 4'hF, 32'd50, 1'b0);
      tick();
      chk("hold_m_data_c1", 64'(m_data), 64'd50);
      req_data[32*3 +: 32] = 32'd99;
      tick();
      chk("hold_m_data_c2", 64'(m_data), 64'd50);
      tick();
      chk("hold_m_data_c3", 64'(m_data), 64'd50);
      chk("hold_req_ready", 64'(req_ready), 64'b1000);
      idle(3);

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
